// File: rtl/frame_fill_engine_if.sv
// Bus bundle for the fill engine: the CPU-facing MMIO register slot and the
// video slot write port that feeds the frame buffer core.
interface frame_fill_engine_if;
  // MMIO register slot
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  // Video slot toward the frame buffer
  logic        v_cs;
  logic        v_write;
  logic [19:0] v_addr;
  logic [31:0] v_wr_data;

  // Engine side: consumes MMIO accesses, drives pixel writes
  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data, v_cs, v_write, v_addr, v_wr_data
  );

  // CPU / frame buffer side
  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data, v_cs, v_write, v_addr, v_wr_data
  );
endinterface

// File: rtl/frame_fill_engine.sv
// Rectangle-fill initiator: the CPU programs origin, size and colour, then
// starts a fill; the engine clips to the screen and issues one pixel write
// per clock on the video slot, reporting busy/done status over MMIO.
module frame_fill_engine #(
  parameter int HRES = 640,
  parameter int VRES = 480,
  parameter int DW   = 9
) (
  input  logic               clk,
  input  logic               reset,
  frame_fill_engine_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam logic [19:0] HRES_A = 20'(HRES);
  localparam logic [11:0] HRES_X = 12'(HRES);
  localparam logic [10:0] VRES_Y = 11'(VRES);

  state_t          state_q, state_d;

  // CPU-visible programmed values
  logic [9:0]      x0_q, x0_d;
  logic [8:0]      y0_q, y0_d;
  logic [10:0]     width_q, width_d;
  logic [9:0]      height_q, height_d;
  logic [DW-1:0]   colour_q, colour_d;

  // Working copies, frozen at start so later register writes cannot disturb a fill
  logic [9:0]      wx_q, wx_d;
  logic [8:0]      wy_q, wy_d;
  logic [10:0]     ew_q, ew_d;
  logic [9:0]      eh_q, eh_d;
  logic [DW-1:0]   wcol_q, wcol_d;

  // Raster walk
  logic [19:0]     row_base_q, row_base_d;
  logic [10:0]     col_q, col_d;
  logic [9:0]      row_q, row_d;

  logic            done_q, done_d;

  logic            wr_en;
  logic            start_p, abort_p, clear_p;
  logic            busy;
  logic            filling;
  logic [11:0]     x_rem;
  logic [10:0]     y_rem;
  logic [10:0]     clip_w;
  logic [9:0]      clip_h;
  logic            fill_empty;
  logic            unused_bits;

  // Only the low 11 data bits carry register fields; read strobe is not needed
  // because read data is a pure function of the address.
  assign unused_bits = ^{bus.read, bus.wr_data[31:11]};

  assign wr_en   = bus.cs & bus.write;
  assign start_p = wr_en && (bus.addr == 5'd5) && bus.wr_data[0];
  assign abort_p = wr_en && (bus.addr == 5'd5) && bus.wr_data[1];
  assign clear_p = wr_en && (bus.addr == 5'd5) && bus.wr_data[2];
  assign busy    = (state_q != ST_IDLE);
  assign filling = (state_q == ST_FILL);

  // Clip the programmed rectangle against the screen edges
  always_comb begin
    x_rem      = HRES_X - {2'b00, x0_q};
    y_rem      = VRES_Y - {2'b00, y0_q};
    clip_w     = ({1'b0, width_q} < x_rem) ? width_q : x_rem[10:0];
    clip_h     = ({1'b0, height_q} < y_rem) ? height_q : y_rem[9:0];
    fill_empty = ({2'b00, x0_q} >= HRES_X) || ({2'b00, y0_q} >= VRES_Y) ||
                 (clip_w == 11'd0) || (clip_h == 10'd0);
  end

  // Register writes, control pulses and fill sequencing
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    width_d    = width_q;
    height_d   = height_q;
    colour_d   = colour_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    ew_d       = ew_q;
    eh_d       = eh_q;
    wcol_d     = wcol_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    done_d     = done_q;

    if (wr_en) begin
      case (bus.addr)
        5'd0:    x0_d     = bus.wr_data[9:0];
        5'd1:    y0_d     = bus.wr_data[8:0];
        5'd2:    width_d  = bus.wr_data[10:0];
        5'd3:    height_d = bus.wr_data[9:0];
        5'd4:    colour_d = bus.wr_data[DW-1:0];
        default: ;
      endcase
    end

    // Clear-done loses to a completing fill, which is applied afterwards
    if (clear_p) begin
      done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Abort in the same write as start suppresses the start
        if (start_p && !abort_p) begin
          if (fill_empty) begin
            done_d = 1'b1;
          end else begin
            wx_d    = x0_q;
            wy_d    = y0_q;
            ew_d    = clip_w;
            eh_d    = clip_h;
            wcol_d  = colour_q;
            done_d  = 1'b0;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        row_base_d = 20'(wy_q) * HRES_A + 20'(wx_q);
        col_d      = 11'd0;
        row_d      = 10'd0;
        state_d    = ST_FILL;
      end
      ST_FILL: begin
        if (col_q == ew_q - 11'd1) begin
          col_d      = 11'd0;
          row_base_d = row_base_q + HRES_A;
          row_d      = row_q + 10'd1;
          if (row_q == eh_q - 10'd1) begin
            state_d = ST_DONE;
          end
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort stops any busy phase immediately; start while busy is ignored above
    if (abort_p && busy) begin
      state_d = ST_IDLE;
    end
  end

  // Pixel write port: active only while walking the rectangle
  always_comb begin
    bus.v_cs      = filling;
    bus.v_write   = filling;
    bus.v_addr    = filling ? (row_base_q + 20'(col_q)) : 20'd0;
    bus.v_wr_data = filling ? 32'(wcol_q) : 32'd0;
  end

  // MMIO read mux, combinational from the address
  always_comb begin
    case (bus.addr)
      5'd0:    bus.rd_data = 32'(x0_q);
      5'd1:    bus.rd_data = 32'(y0_q);
      5'd2:    bus.rd_data = 32'(width_q);
      5'd3:    bus.rd_data = 32'(height_q);
      5'd4:    bus.rd_data = 32'(colour_q);
      5'd6:    bus.rd_data = {30'd0, done_q, busy};
      default: bus.rd_data = 32'd0;
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      width_q    <= '0;
      height_q   <= '0;
      colour_q   <= '0;
      wx_q       <= '0;
      wy_q       <= '0;
      ew_q       <= '0;
      eh_q       <= '0;
      wcol_q     <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      width_q    <= width_d;
      height_q   <= height_d;
      colour_q   <= colour_d;
      wx_q       <= wx_d;
      wy_q       <= wy_d;
      ew_q       <= ew_d;
      eh_q       <= eh_d;
      wcol_q     <= wcol_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_frame_fill_engine.sv
// Bench for the rectangle-fill engine: directed scenarios plus random fills,
// checked against a pixel-list model built from clipping arithmetic.
module tb_frame_fill_engine;
  localparam int HRES = 640;
  localparam int VRES = 480;
  localparam int DW   = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  frame_fill_engine_if bus();

  frame_fill_engine #(.HRES(HRES), .VRES(VRES), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int obs_addr[$];
  int obs_data[$];
  int obs_cyc[$];
  int exp_addr[$];
  int exp_data[$];
  int start_cyc, busy_cnt, busy_first, done_first;
  int m_x0, m_y0, m_w, m_h, m_col;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // Observe the video slot and the status register away from the clock edge
  always @(negedge clk) begin
    if (bus.v_cs && bus.v_write) begin
      obs_addr.push_back(int'(bus.v_addr));
      obs_data.push_back(int'(bus.v_wr_data));
      obs_cyc.push_back(cyc);
      check_val("v_addr_range", {31'd0, (int'(bus.v_addr) < HRES * VRES)}, 32'd1);
    end
    if (!reset && bus.cs && bus.read && bus.addr == 5'd6) begin
      if (bus.rd_data[0]) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
      end
      if (bus.rd_data[1] && done_first < 0) done_first = cyc;
    end
  end

  task automatic mmio_wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.read = 1'b0; bus.addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic mmio_rd(input logic [4:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.addr = a;
    #1;
    d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic program_rect(input int x0, input int y0, input int w, input int h, input int col);
    m_x0 = x0 & 32'h3ff; m_y0 = y0 & 32'h1ff; m_w = w & 32'h7ff;
    m_h = h & 32'h3ff; m_col = col & ((1 << DW) - 1);
    mmio_wr(5'd0, 32'(x0));
    mmio_wr(5'd1, 32'(y0));
    mmio_wr(5'd2, 32'(w));
    mmio_wr(5'd3, 32'(h));
    mmio_wr(5'd4, 32'(col));
  endtask

  // Reference: every on-screen pixel of the rectangle, raster order
  function automatic void build_expected();
    int ew, eh;
    exp_addr.delete(); exp_data.delete();
    ew = (m_x0 >= HRES) ? 0 : ((m_w < HRES - m_x0) ? m_w : HRES - m_x0);
    eh = (m_y0 >= VRES) ? 0 : ((m_h < VRES - m_y0) ? m_h : VRES - m_y0);
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++) begin
        exp_addr.push_back((m_y0 + r) * HRES + m_x0 + c);
        exp_data.push_back(m_col);
      end
  endfunction

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    busy_cnt = 0; busy_first = -1; done_first = -1;
  endtask

  task automatic start_fill();
    build_expected();
    clear_obs();
    start_cyc = cyc;
    mmio_wr(5'd5, 32'd1);
  endtask

  // Hold the status address on the bus for a bounded number of cycles
  task automatic watch(input int ncyc);
    bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.addr = 5'd6;
    repeat (ncyc) @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n);
    check_val({tag, "_wr_count"}, 32'(obs_addr.size()), 32'(n));
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      check_val({tag, "_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
      check_val({tag, "_data"}, 32'(obs_data[i]), 32'(exp_data[i]));
      check_val({tag, "_wr_cycle"}, 32'(obs_cyc[i]), 32'(start_cyc + 2 + i));
    end
  endtask

  task automatic check_timing(input string tag);
    int n;
    logic [31:0] st;
    n = exp_addr.size();
    if (n > 0) begin
      check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n + 2));
      check_val({tag, "_busy_first"}, 32'(busy_first), 32'(start_cyc + 1));
      check_val({tag, "_done_first"}, 32'(done_first), 32'(start_cyc + n + 3));
    end else begin
      check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd0);
      check_val({tag, "_done_first"}, 32'(done_first), 32'(start_cyc + 1));
    end
    mmio_rd(5'd6, st);
    check_val({tag, "_status"}, st, 32'h2);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    mmio_rd(5'd0, d); check_val({tag, "_rd_x0"}, d, 32'(m_x0));
    mmio_rd(5'd1, d); check_val({tag, "_rd_y0"}, d, 32'(m_y0));
    mmio_rd(5'd2, d); check_val({tag, "_rd_w"}, d, 32'(m_w));
    mmio_rd(5'd3, d); check_val({tag, "_rd_h"}, d, 32'(m_h));
    mmio_rd(5'd4, d); check_val({tag, "_rd_col"}, d, 32'(m_col));
  endtask

  task automatic full_fill(input string tag, input int x0, input int y0, input int w, input int h, input int col);
    program_rect(x0, y0, w, h, col);
    start_fill();
    watch(exp_addr.size() + 6);
    check_writes(tag, exp_addr.size());
    check_timing(tag);
    $display("%s: x0=%0d y0=%0d w=%0d h=%0d col=0x%0h -> %0d writes (expected %0d)",
             tag, m_x0, m_y0, m_w, m_h, m_col, obs_addr.size(), exp_addr.size());
  endtask

  initial begin
    logic [31:0] d;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_col = 0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check_val("rst_v_cs", {31'd0, bus.v_cs}, 32'd0);
    check_val("rst_v_addr", 32'(bus.v_addr), 32'd0);
    check_val("rst_v_wr_data", bus.v_wr_data, 32'd0);
    mmio_rd(5'd6, d); check_val("rst_status", d, 32'd0);
    check_regs("rst");

    // Basic 3x2 fill
    full_fill("basic", 10, 20, 3, 2, 32'h1A5);
    check_regs("basic");

    // Clipped at bottom-right corner
    full_fill("clip", 638, 479, 5, 4, 32'h0C3);

    // Zero width: no writes, done one cycle after start
    full_fill("empty", 200, 100, 0, 3, 32'h011);

    // Clear-done drops the sticky flag
    mmio_wr(5'd5, 32'd4);
    mmio_rd(5'd6, d); check_val("clear_done_status", d, 32'd0);

    // Abort after the fifth pixel, then a full fill
    program_rect(0, 0, 4, 4, 32'h0F0);
    start_fill();
    repeat (5) @(posedge clk);
    #1;
    mmio_wr(5'd5, 32'd2);
    watch(6);
    check_writes("abort", 5);
    mmio_rd(5'd6, d); check_val("abort_status", d, 32'd0);
    $display("abort: %0d writes before abort (expected 5)", obs_addr.size());
    start_fill();
    watch(exp_addr.size() + 6);
    check_writes("after_abort", exp_addr.size());
    check_timing("after_abort");
    $display("after_abort: %0d writes (expected %0d)", obs_addr.size(), exp_addr.size());

    // Start plus colour/width rewrite while busy are ignored by the fill in progress
    program_rect(100, 50, 2, 2, 32'h0AA);
    start_fill();
    mmio_wr(5'd4, 32'h155);
    mmio_wr(5'd5, 32'd1);
    mmio_wr(5'd2, 32'd7);
    m_col = 32'h155; m_w = 7;
    watch(6);
    check_writes("restart_ignored", exp_addr.size());
    mmio_rd(5'd6, d); check_val("restart_ignored_status", d, 32'h2);
    check_regs("restart_ignored");
    $display("restart_ignored: %0d writes (expected %0d)", obs_addr.size(), exp_addr.size());

    // Abort together with start while idle: no fill, done untouched
    clear_obs();
    mmio_wr(5'd5, 32'd3);
    watch(4);
    check_val("abort_start_writes", 32'(obs_addr.size()), 32'd0);
    check_val("abort_start_busy", 32'(busy_cnt), 32'd0);
    mmio_rd(5'd6, d); check_val("abort_start_status", d, 32'h2);
    $display("abort_start: %0d writes (expected 0)", obs_addr.size());

    // Random rectangles biased toward the screen edges
    for (int t = 0; t < 10; t++) begin
      int rx, ry;
      rx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(HRES - 6, HRES + 2)) : int'($urandom_range(0, HRES - 1));
      ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(VRES - 5, VRES + 2)) : int'($urandom_range(0, VRES - 1));
      full_fill("rand", rx, ry, int'($urandom_range(0, 9)), int'($urandom_range(0, 6)), int'($urandom_range(0, 511)));
      check_regs("rand");
    end

    // Reset pulse mid-fill stops writes and clears everything
    program_rect(0, 0, 4, 4, 32'h033);
    start_fill();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    watch(6);
    check_val("reset_mid_writes", 32'(obs_addr.size()), 32'd3);
    m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_col = 0;
    check_regs("reset_mid");
    mmio_rd(5'd6, d); check_val("reset_mid_status", d, 32'd0);
    $display("reset_mid: %0d writes before reset (expected 3)", obs_addr.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
